// File: rtl/sga_pkg.sv
// Shared constants and types for the Snake Game serial status transmitter.
// SGA_TX_PARITY_EN adds the PARITY state to the TX FSM encoding.
package sga_pkg;

  localparam int NUM_CHARS = 10;

  localparam logic [7:0] ASC_H  = 8'h48;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_UA = 8'h41;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4
`ifdef SGA_TX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } tx_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASC_0 + {4'd0, nib};
    else             return ASC_UA + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/sga_uart_tx_core.sv
// Baud divider and bit serialiser: 8N1 by default, 8E1 with SGA_TX_PARITY_EN.
// tx and done are registered so the line never glitches and done follows the stop bit.
module sga_uart_tx_core
  import sga_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       done,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int              CW   = $clog2(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tx_nx;
  logic          tick;
`ifdef SGA_TX_PARITY_EN
  logic          par;
`endif

  assign tick      = (baud_cnt == LAST);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  // tx_nx is the line level for the cycle after this one, so the line lags state by one clock.
  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    case (state)
      S_IDLE:  if (start) state_nx = S_START;
      S_START: begin
        tx_nx = 1'b0;
        if (tick) state_nx = S_DATA;
      end
      S_DATA: begin
        tx_nx = shreg[0];
`ifdef SGA_TX_PARITY_EN
        if (tick && bit_cnt == 3'd7) state_nx = S_PARITY;
`else
        if (tick && bit_cnt == 3'd7) state_nx = S_STOP;
`endif
      end
`ifdef SGA_TX_PARITY_EN
      S_PARITY: begin
        tx_nx = par;
        if (tick) state_nx = S_STOP;
      end
`endif
      S_STOP:  if (tick) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      tx       <= 1'b1;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef SGA_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx   <= tx_nx;
      done <= (state == S_DONE);
      // Restarting on every state entry keeps each character aligned to its own start.
      if (state_nx != state || tick) baud_cnt <= '0;
      else if (state != S_IDLE)       baud_cnt <= baud_cnt + 1'b1;
      if (state == S_IDLE && start) begin
        shreg   <= data;
        bit_cnt <= '0;
`ifdef SGA_TX_PARITY_EN
        par     <= ^data;
`endif
      end else if (state == S_DATA && tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sga_serial_tx.sv
// Snake Game status transmitter: index counter, snapshot register and ASCII mux
// around the UART core. SGA_TX_PARITY_EN selects 8E1 framing in the core.
module sga_serial_tx
  import sga_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int NUM_CHARS = sga_pkg::NUM_CHARS
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       comeca_transmissao,
  input  logic       conta_digito,
  input  logic [7:0] head_pos,
  input  logic [7:0] apple_pos,
  input  logic [7:0] size,
  output logic       tx,
  output logic       fim_digito,
  output logic       fim_envio,
  output logic       busy,
  output logic [2:0] db_tx_state
);

  localparam int            DIV      = CLK_FREQ / BAUD;
  localparam int            IW       = $clog2(NUM_CHARS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHARS - 1);

  logic [IW-1:0] index;
  logic [7:0]    snap_head, snap_apple, snap_size;
  logic [7:0]    char_data;
  logic          accept;

  assign accept    = comeca_transmissao && !busy;
  assign fim_envio = (index == LAST_IDX);

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      index <= '0;
    end else if (conta_digito) begin
      index <= (index == LAST_IDX) ? '0 : index + 1'b1;
    end
  end

  // Character 0 is a constant, so latching on its accept still feeds characters 1..8.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      snap_head  <= '0;
      snap_apple <= '0;
      snap_size  <= '0;
    end else if (accept && index == '0) begin
      snap_head  <= head_pos;
      snap_apple <= apple_pos;
      snap_size  <= size;
    end
  end

  always_comb begin
    char_data = ASC_LF;
    case (int'(index))
      0:       char_data = ASC_H;
      1:       char_data = hex_ascii(snap_head[7:4]);
      2:       char_data = hex_ascii(snap_head[3:0]);
      3:       char_data = ASC_A;
      4:       char_data = hex_ascii(snap_apple[7:4]);
      5:       char_data = hex_ascii(snap_apple[3:0]);
      6:       char_data = ASC_S;
      7:       char_data = hex_ascii(snap_size[7:4]);
      8:       char_data = hex_ascii(snap_size[3:0]);
      9:       char_data = ASC_CR;
      default: char_data = ASC_LF;
    endcase
  end

  sga_uart_tx_core #(
    .DIV (DIV)
  ) u_core (
    .clock     (clock),
    .restart_n (restart_n),
    .data      (char_data),
    .start     (comeca_transmissao),
    .tx        (tx),
    .done      (fim_digito),
    .busy      (busy),
    .state_dbg (db_tx_state)
  );

endmodule

// File: tb/tb_sga_serial_tx.sv
// Scoreboard bench for sga_serial_tx at DIV=16: a line receiver decodes tx and
// compares each byte against the queue filled when the character is started.
module tb_sga_serial_tx;

  localparam int DIV = 16;
`ifdef SGA_TX_PARITY_EN
  localparam int LAT = 11 * DIV + 1;
`else
  localparam int LAT = 10 * DIV + 1;
`endif

  logic       clock = 1'b0;
  logic       restart_n = 1'b0;
  logic       comeca_transmissao = 1'b0;
  logic       conta_digito = 1'b0;
  logic [7:0] head_pos = '0;
  logic [7:0] apple_pos = '0;
  logic [7:0] size = '0;
  logic       tx, fim_digito, fim_envio, busy;
  logic [2:0] db_tx_state;

  int         vectors = 0;
  int         miscompares = 0;
  int         fim_cnt = 0;
  logic [7:0] sb[$];
  logic       mon_en = 1'b1;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always #5 clock = ~clock;

  sga_serial_tx #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .NUM_CHARS (10)
  ) dut (
    .clock              (clock),
    .restart_n          (restart_n),
    .comeca_transmissao (comeca_transmissao),
    .conta_digito       (conta_digito),
    .head_pos           (head_pos),
    .apple_pos          (apple_pos),
    .size               (size),
    .tx                 (tx),
    .fim_digito         (fim_digito),
    .fim_envio          (fim_envio),
    .busy               (busy),
    .db_tx_state        (db_tx_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  always @(negedge clock) if (fim_digito) fim_cnt++;

  // Line receiver: mid-bit sampling on falling clock edges.
  always begin
    @(negedge tx);
    if (mon_en && restart_n) begin
      repeat (DIV / 2) @(negedge clock);
      check("start_bit", tx, 0);
      for (int b = 0; b < 8; b++) begin
        repeat (DIV) @(negedge clock);
        rx_byte[b] = tx;
      end
`ifdef SGA_TX_PARITY_EN
      repeat (DIV) @(negedge clock);
      check("parity_bit", tx, ^rx_byte);
`endif
      repeat (DIV) @(negedge clock);
      check("stop_bit", tx, 1);
      check("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        rx_exp = sb.pop_front();
        check("rx_char", rx_byte, rx_exp);
      end
    end
  end

  task automatic pulse_conta();
    @(negedge clock); conta_digito = 1'b1;
    @(negedge clock); conta_digito = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] exp, input logic with_conta);
    int cyc;
    if (mon_en) sb.push_back(exp);
    @(negedge clock); comeca_transmissao = 1'b1; conta_digito = with_conta;
    @(negedge clock); comeca_transmissao = 1'b0; conta_digito = 1'b0;
    check("tx_high_at_accept", tx, 1);
    cyc = 0;
    @(negedge clock); cyc++;
    check("tx_start_low", tx, 0);
    check("busy_during_char", busy, 1);
    while (!fim_digito && cyc < LAT + 50) begin
      @(negedge clock); cyc++;
    end
    check("fim_latency", cyc, LAT);
    @(negedge clock);
    check("fim_one_cycle", fim_digito, 0);
  endtask

  task automatic frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] s,
                       input logic [7:0] h_late);
    logic [7:0] exp [10];
    exp = '{8'h48, hexc(h[7:4]), hexc(h[3:0]), 8'h41, hexc(a[7:4]), hexc(a[3:0]),
            8'h53, hexc(s[7:4]), hexc(s[3:0]), 8'h0D};
    head_pos = h; apple_pos = a; size = s;
    for (int i = 0; i < 10; i++) begin
      check("fim_envio_idx", fim_envio, (i == 9));
      send_char(exp[i], 1'b0);
      if (i == 0) head_pos = h_late;
      pulse_conta();
    end
    check("fim_envio_after_wrap", fim_envio, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fims;

    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_fim_digito", fim_digito, 0);
    check("rst_busy", busy, 0);
    check("rst_fim_envio", fim_envio, 0);
    check("rst_state", db_tx_state, 0);
    restart_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single 'H' after reset, latency and line pattern.
    send_char(8'h48, 1'b0);

    // Full frame; head changes after char 0 starts but the snapshot holds.
    frame(8'h3A, 8'h07, 8'hFF, 8'h11);
    // Next frame picks up the new head value and starts again at 'H'.
    frame(8'h11, 8'hB2, 8'h04, 8'h11);

    // Second start mid-character is ignored.
    sb.push_back(8'h48);
    fims = fim_cnt;
    @(negedge clock); comeca_transmissao = 1'b1;
    @(negedge clock); comeca_transmissao = 1'b0;
    repeat (50) @(negedge clock);
    comeca_transmissao = 1'b1;
    @(negedge clock); comeca_transmissao = 1'b0;
    check("busy_after_ignored_start", busy, 1);
    repeat (LAT + 150) @(negedge clock);
    check("single_fim_digito", fim_cnt - fims, 1);
    check("idle_after_ignored", busy, 0);

    // Simultaneous start and advance in IDLE: old index sent, then index moves.
    head_pos = 8'hC5;
    send_char(8'h48, 1'b1);
    send_char(8'h43, 1'b0);

    // Reset during data bit 4 of the character at index 1.
    mon_en = 1'b0;
    fims = fim_cnt;
    @(negedge clock); comeca_transmissao = 1'b1;
    @(negedge clock); comeca_transmissao = 1'b0;
    repeat (89) @(negedge clock);
    check("state_data_before_rst", db_tx_state, 2);
    #2 restart_n = 1'b0;
    #1;
    check("rst_mid_tx_high", tx, 1);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clock);
    restart_n = 1'b1;
    repeat (LAT + 20) @(negedge clock);
    check("no_fim_after_rst", fim_cnt - fims, 0);
    check("tx_idle_after_rst", tx, 1);
    mon_en = 1'b1;
    send_char(8'h48, 1'b0);

    // 'A' at index 3 (parity 0 when 8E1 is built).
    repeat (3) pulse_conta();
    send_char(8'h41, 1'b0);

    repeat (20) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
